// File: rtl/color_loop_if.sv
// color_loop bus definitions: shared data types plus the interface that
// carries the start/done handshake, triangle parameters and the wireframe,
// z-buffer and frame-buffer memory ports.
// master: the fill engine itself. slave: the environment (memories, sequencer).

package color_loop_pkg;
  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } Vertex;

  typedef struct packed {
    Vertex p;
    Vertex q;
    Vertex r;
  } Triangle3D;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } Color;
endpackage

interface color_loop_if #(
  parameter int LAYER_SIZE = 8,
  parameter int ADDR_SIZE  = 19
);
  import color_loop_pkg::*;

  logic                   color_en;
  Triangle3D              ver;
  Color                   rgb_val;
  logic signed [15:0]     height;
  logic                   sram_val;
  logic [LAYER_SIZE-1:0]  zbuf_val;
  logic                   done;
  logic [ADDR_SIZE-1:0]   sram_addr;
  logic [ADDR_SIZE-1:0]   zbuf_addr;
  logic [ADDR_SIZE-1:0]   fb_addr;
  logic                   write_en;
  logic [LAYER_SIZE-1:0]  data_out;
  Color                   data_out_color;

  modport master (
    input  color_en, ver, rgb_val, height, sram_val, zbuf_val,
    output done, sram_addr, zbuf_addr, fb_addr, write_en, data_out, data_out_color
  );

  modport slave (
    output color_en, ver, rgb_val, height, sram_val, zbuf_val,
    input  done, sram_addr, zbuf_addr, fb_addr, write_en, data_out, data_out_color
  );
endinterface

// File: rtl/color_loop.sv
// color_loop: rasterizer span-fill stage.
// Scans the clamped bounding box of a triangle row by row, finds the leftmost
// and rightmost wireframe pixels of each row and writes colour/depth over the
// span between them. Every memory access is ADDR, WAIT, then sample/test.
// Build option: define ZTEST_EN to gate writes on depth > stored z (unsigned);
// without it every span pixel is written and zbuf_val is ignored.
//
// state   | meaning
// IDLE    | waiting for color_en, latches box/depth/colour on start
// LSCAN   | scanning right from xmin for the left edge pixel
// RSCAN   | scanning left from xmax for the right edge pixel
// FILL    | writing each pixel of [left, right]
// NEXTROW | advance to the next row or finish
// DONE    | done=1 until color_en drops

module color_loop
  import color_loop_pkg::*;
#(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int LAYER_SIZE = 8,
  parameter int ADDR_SIZE  = 19
) (
  input  logic        clk,
  input  logic        n_rst,
  color_loop_if.master bus
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LSCAN   = 3'd1;
  localparam logic [2:0] S_RSCAN   = 3'd2;
  localparam logic [2:0] S_FILL    = 3'd3;
  localparam logic [2:0] S_NEXTROW = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  // Read data becomes valid in the third cycle after an address change.
  localparam logic [1:0] PH_ADDR   = 2'd0;
  localparam logic [1:0] PH_WAIT   = 2'd1;
  localparam logic [1:0] PH_SAMPLE = 2'd2;

  logic [2:0]            state;
  logic [1:0]            phase;
  logic [XW-1:0]         x, xmin, xmax, left, right;
  logic [YW-1:0]         y, ymin, ymax;
  logic [ADDR_SIZE-1:0]  addr_r;
  logic [LAYER_SIZE-1:0] depth_r;
  Color                  color_r;

  logic [XW-1:0]         bx_min, bx_max, x_inc, x_dec;
  logic [YW-1:0]         by_min, by_max, y_inc;
  logic                  z_pass;

  function automatic logic signed [15:0] min3(input logic signed [15:0] a,
                                              input logic signed [15:0] b,
                                              input logic signed [15:0] c);
    logic signed [15:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic signed [15:0] max3(input logic signed [15:0] a,
                                              input logic signed [15:0] b,
                                              input logic signed [15:0] c);
    logic signed [15:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [15:0] clamp(input logic signed [15:0] v,
                                        input logic signed [15:0] hi);
    if (v < 16'sd0) return '0;
    else if (v > hi) return hi;
    else return v;
  endfunction

  function automatic logic [ADDR_SIZE-1:0] pix(input logic [YW-1:0] yy,
                                               input logic [XW-1:0] xx);
    return ADDR_SIZE'(yy) * ADDR_SIZE'(WIDTH) + ADDR_SIZE'(xx);
  endfunction

  // Bounding box of the incoming triangle, clamped to the screen.
  assign bx_min = XW'(clamp(min3(bus.ver.p.x, bus.ver.q.x, bus.ver.r.x), 16'(WIDTH - 1)));
  assign bx_max = XW'(clamp(max3(bus.ver.p.x, bus.ver.q.x, bus.ver.r.x), 16'(WIDTH - 1)));
  assign by_min = YW'(clamp(min3(bus.ver.p.y, bus.ver.q.y, bus.ver.r.y), 16'(HEIGHT - 1)));
  assign by_max = YW'(clamp(max3(bus.ver.p.y, bus.ver.q.y, bus.ver.r.y), 16'(HEIGHT - 1)));

  assign x_inc = x + 1'b1;
  assign x_dec = x - 1'b1;
  assign y_inc = y + 1'b1;

`ifdef ZTEST_EN
  assign z_pass = (depth_r > bus.zbuf_val);
`else
  logic unused_zbuf;
  assign z_pass      = 1'b1;
  assign unused_zbuf = ^bus.zbuf_val;
`endif

  // Only p.z sets the layer depth.
  logic unused_z;
  assign unused_z = ^{bus.ver.q.z, bus.ver.r.z};

  // All three memories see the same pixel address.
  assign bus.sram_addr      = addr_r;
  assign bus.zbuf_addr      = addr_r;
  assign bus.fb_addr        = addr_r;
  assign bus.write_en       = (state == S_FILL) && (phase == PH_SAMPLE) && z_pass;
  assign bus.done           = (state == S_DONE);
  assign bus.data_out       = depth_r;
  assign bus.data_out_color = color_r;

  // Scan/fill sequencer; the address register only moves inside the box.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state   <= S_IDLE;
      phase   <= PH_ADDR;
      x       <= '0;
      y       <= '0;
      xmin    <= '0;
      xmax    <= '0;
      ymin    <= '0;
      ymax    <= '0;
      left    <= '0;
      right   <= '0;
      addr_r  <= '0;
      depth_r <= '0;
      color_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.color_en) begin
            xmin    <= bx_min;
            xmax    <= bx_max;
            ymin    <= by_min;
            ymax    <= by_max;
            x       <= bx_min;
            y       <= by_min;
            addr_r  <= pix(by_min, bx_min);
            depth_r <= LAYER_SIZE'(bus.ver.p.z + bus.height);
            color_r <= bus.rgb_val;
            phase   <= PH_ADDR;
            state   <= S_LSCAN;
          end
        end
        S_LSCAN: begin
          if (phase != PH_SAMPLE) begin
            phase <= phase + 2'd1;
          end else if (bus.sram_val) begin
            left   <= x;
            x      <= xmax;
            addr_r <= pix(y, xmax);
            phase  <= PH_ADDR;
            state  <= S_RSCAN;
          end else if (x == xmax) begin
            state <= S_NEXTROW;
          end else begin
            x      <= x_inc;
            addr_r <= pix(y, x_inc);
            phase  <= PH_ADDR;
          end
        end
        S_RSCAN: begin
          if (phase != PH_SAMPLE) begin
            phase <= phase + 2'd1;
          end else if (bus.sram_val || (x == left)) begin
            right  <= x;
            x      <= left;
            addr_r <= pix(y, left);
            phase  <= PH_ADDR;
            state  <= S_FILL;
          end else begin
            x      <= x_dec;
            addr_r <= pix(y, x_dec);
            phase  <= PH_ADDR;
          end
        end
        S_FILL: begin
          if (phase != PH_SAMPLE) begin
            phase <= phase + 2'd1;
          end else if (x == right) begin
            state <= S_NEXTROW;
          end else begin
            x      <= x_inc;
            addr_r <= pix(y, x_inc);
            phase  <= PH_ADDR;
          end
        end
        S_NEXTROW: begin
          phase <= PH_ADDR;
          if (y == ymax) begin
            state <= S_DONE;
          end else begin
            y      <= y_inc;
            x      <= xmin;
            addr_r <= pix(y_inc, xmin);
            state  <= S_LSCAN;
          end
        end
        S_DONE: begin
          if (!bus.color_en) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_color_loop.sv
// Bench for color_loop: models the three memories with two-cycle read latency,
// predicts the final frame/z-buffer images, write counts and cycle counts from
// a row-by-row span model, and watches the bus every cycle.
`timescale 1ns/1ps
module tb_color_loop;
  import color_loop_pkg::*;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int N  = W * H;
  localparam int LS = 8;
  localparam int AS = 19;
`ifdef ZTEST_EN
  localparam bit ZT = 1'b1;
`else
  localparam bit ZT = 1'b0;
`endif

  logic tb_clk = 1'b0;
  logic n_rst;
  always #5 tb_clk = ~tb_clk;

  color_loop_if #(.LAYER_SIZE(LS), .ADDR_SIZE(AS)) bus ();

  color_loop #(.WIDTH(W), .HEIGHT(H), .LAYER_SIZE(LS), .ADDR_SIZE(AS)) dut (
    .clk  (tb_clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  bit          wf    [N];
  logic [7:0]  zmem  [N];
  logic [7:0]  zexp  [N];
  logic [23:0] fbmem [N];
  logic [23:0] fbexp [N];

  logic [AS-1:0] rd1 = '0, rd2 = '0, zr1 = '0, zr2 = '0;
  int n_assert = 0, n_fail = 0, wr_cnt = 0;
  int bxmin, bxmax, bymin, bymax, last_cyc, last_wr;
  bit mon_on = 1'b0, box_on = 1'b0, we_prev = 1'b0;
  logic [7:0]  exp_depth = '0;
  logic [23:0] exp_col = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memories: read data follows the address by two clocks.
  always @(posedge tb_clk) begin
    rd1 <= bus.sram_addr; rd2 <= rd1;
    zr1 <= bus.zbuf_addr; zr2 <= zr1;
  end
  assign bus.sram_val = (int'(rd2) < N) ? wf[rd2] : 1'b0;
  assign bus.zbuf_val = (int'(zr2) < N) ? zmem[zr2] : '0;

  always @(posedge tb_clk) begin
    if (bus.write_en === 1'b1 && int'(bus.fb_addr) < N && int'(bus.zbuf_addr) < N) begin
      zmem[bus.zbuf_addr] <= bus.data_out;
      fbmem[bus.fb_addr]  <= bus.data_out_color;
    end
  end

  // Bus monitor.
  always @(negedge tb_clk) begin
    if (mon_on) begin
      int a, ax, ay;
      a  = int'(bus.sram_addr);
      ax = a % W;
      ay = a / W;
      chk("addr_eq_zbuf", bus.zbuf_addr, bus.sram_addr);
      chk("addr_eq_fb", bus.fb_addr, bus.sram_addr);
      chk("addr_range", (a < N), 1);
      if (box_on)
        chk("addr_in_box", (ax >= bxmin && ax <= bxmax && ay >= bymin && ay <= bymax), 1);
      if (bus.write_en === 1'b1) begin
        chk("we_one_cycle", we_prev, 0);
        chk("wr_depth", bus.data_out, exp_depth);
        chk("wr_color", bus.data_out_color, exp_col);
        wr_cnt++;
      end
      we_prev = (bus.write_en === 1'b1);
    end
  end

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic plot(input int x, input int y);
    if (x >= 0 && x < W && y >= 0 && y < H) wf[y * W + x] = 1'b1;
  endtask

  task automatic draw_line(input int x0, input int y0, input int x1, input int y1);
    int st;
    st = (iabs(x1 - x0) > iabs(y1 - y0)) ? iabs(x1 - x0) : iabs(y1 - y0);
    if (st == 0) plot(x0, y0);
    else for (int i = 0; i <= st; i++)
      plot(x0 + ((x1 - x0) * i) / st, y0 + ((y1 - y0) * i) / st);
  endtask

  task automatic clear_wf();
    for (int i = 0; i < N; i++) wf[i] = 1'b0;
  endtask

  task automatic set_box(input int px, input int py, input int qx, input int qy,
                         input int rx, input int ry);
    int lo, hi;
    lo = (px < qx) ? px : qx; lo = (lo < rx) ? lo : rx;
    hi = (px > qx) ? px : qx; hi = (hi > rx) ? hi : rx;
    bxmin = clampi(lo, W - 1); bxmax = clampi(hi, W - 1);
    lo = (py < qy) ? py : qy; lo = (lo < ry) ? lo : ry;
    hi = (py > qy) ? py : qy; hi = (hi > ry) ? hi : ry;
    bymin = clampi(lo, H - 1); bymax = clampi(hi, H - 1);
  endtask

  // Row-by-row span model: final memory image, writes and cycle cost.
  task automatic model(output int exp_cyc, output int exp_wr);
    int lft, rgt, w, a;
    zexp = zmem;
    fbexp = fbmem;
    exp_cyc = 1;
    exp_wr = 0;
    w = bxmax - bxmin + 1;
    for (int yy = bymin; yy <= bymax; yy++) begin
      lft = -1;
      rgt = -1;
      for (int xx = bxmin; xx <= bxmax && lft < 0; xx++) if (wf[yy * W + xx]) lft = xx;
      if (lft < 0) begin
        exp_cyc += 3 * w + 1;
      end else begin
        for (int xx = bxmax; xx >= lft && rgt < 0; xx--) if (wf[yy * W + xx]) rgt = xx;
        for (int xx = lft; xx <= rgt; xx++) begin
          a = yy * W + xx;
          if (!ZT || exp_depth > zexp[a]) begin
            zexp[a] = exp_depth;
            fbexp[a] = exp_col;
            exp_wr++;
          end
        end
        exp_cyc += 3 * (lft - bxmin + 1) + 3 * (bxmax - rgt + 1) + 3 * (rgt - lft + 1) + 1;
      end
    end
  endtask

  task automatic load_tri(input int px, input int py, input int pz, input int qx, input int qy,
                          input int qz, input int rx, input int ry, input int rz,
                          input int hgt, input logic [23:0] col);
    bus.ver.p.x = 16'(px); bus.ver.p.y = 16'(py); bus.ver.p.z = 16'(pz);
    bus.ver.q.x = 16'(qx); bus.ver.q.y = 16'(qy); bus.ver.q.z = 16'(qz);
    bus.ver.r.x = 16'(rx); bus.ver.r.y = 16'(ry); bus.ver.r.z = 16'(rz);
    bus.height  = 16'(hgt);
    bus.rgb_val = col;
    exp_depth   = 8'(pz + hgt);
    exp_col     = col;
    set_box(px, py, qx, qy, rx, ry);
  endtask

  task automatic run_fill(input int px, input int py, input int pz, input int qx, input int qy,
                          input int qz, input int rx, input int ry, input int rz,
                          input int hgt, input logic [23:0] col, input bit toggle);
    int cyc, exp_cyc, exp_wr, errs;
    load_tri(px, py, pz, qx, qy, qz, rx, ry, rz, hgt, col);
    model(exp_cyc, exp_wr);
    wr_cnt = 0;
    @(negedge tb_clk);
    bus.color_en = 1'b1;
    @(posedge tb_clk);
    cyc = 1;
    @(negedge tb_clk);
    chk("start_addr", bus.sram_addr, 64'(bymin * W + bxmin));
    box_on = 1'b1;
    while (bus.done !== 1'b1 && cyc < 60000) begin
      @(posedge tb_clk);
      cyc++;
      @(negedge tb_clk);
      if (toggle && cyc == 20) bus.color_en = 1'b0;
      if (toggle && cyc == 26) bus.color_en = 1'b1;
    end
    chk("done_in_time", bus.done, 1);
    chk("cycles", cyc, exp_cyc);
    chk("writes", wr_cnt, exp_wr);
    last_cyc = cyc;
    last_wr  = wr_cnt;
    repeat (3) begin
      @(negedge tb_clk);
      chk("done_hold", bus.done, 1);
    end
    bus.color_en = 1'b0;
    @(negedge tb_clk);
    chk("done_clear", bus.done, 0);
    box_on = 1'b0;
    errs = 0;
    for (int i = 0; i < N; i++)
      if (fbmem[i] !== fbexp[i] || zmem[i] !== zexp[i]) errs++;
    chk("mem_image", errs, 0);
  endtask

  task automatic chk_outputs_zero();
    chk("rst_done", bus.done, 0);
    chk("rst_write_en", bus.write_en, 0);
    chk("rst_sram_addr", bus.sram_addr, 0);
    chk("rst_zbuf_addr", bus.zbuf_addr, 0);
    chk("rst_fb_addr", bus.fb_addr, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_data_color", bus.data_out_color, 0);
  endtask

  initial begin
    int ox, oy, cyc, w0;
    n_rst = 1'b1;
    bus.color_en = 1'b0;
    bus.ver = '0;
    bus.rgb_val = '0;
    bus.height = '0;
    for (int i = 0; i < N; i++) begin
      wf[i] = 1'b0; zmem[i] = '0; fbmem[i] = '0;
    end
    repeat (3) @(negedge tb_clk);
    chk_outputs_zero();
    n_rst = 1'b0;
    mon_on = 1'b1;
    @(negedge tb_clk);

    // Right triangle, z=100, with color_en wobbling mid-fill.
    clear_wf();
    draw_line(0, 0, 0, 39); draw_line(0, 39, 53, 39); draw_line(53, 39, 0, 0);
    run_fill(0, 0, 100, 0, 39, 100, 53, 39, 100, 0, 24'hFF190C, 1'b1);
    chk("A_origin_color", fbmem[0], 24'hFF190C);
    chk("A_origin_depth", zmem[0], 8'd100);
    chk("A_above_diag", fbmem[5 * W + 50], 24'h0);

    // Overlapping triangle at z=30.
    clear_wf();
    draw_line(10, 10, 40, 40); draw_line(40, 40, 5, 30); draw_line(5, 30, 10, 10);
    run_fill(10, 10, 30, 40, 40, 30, 5, 30, 30, 0, 24'h19FF0C, 1'b0);
    chk("B_overlap", fbmem[30 * W + 20], ZT ? 24'hFF190C : 24'h19FF0C);
    chk("B_outside_A", fbmem[40 * W + 40], 24'h19FF0C);

    // Empty wireframe over an 11x11 box.
    clear_wf();
    run_fill(10, 10, 5, 20, 20, 5, 10, 20, 5, 0, 24'hABCDEF, 1'b0);
    chk("empty_writes", last_wr, 0);
    chk("empty_cycles", last_cyc, 1 + 11 * (3 * 11 + 1));

    // Off-screen vertices clamp to the screen edge.
    clear_wf();
    draw_line(-5, 470, 12, 500); draw_line(12, 500, 3, 475); draw_line(3, 475, -5, 470);
    run_fill(-5, 470, 20, 12, 500, 20, 3, 475, 20, 3, 24'h112233, 1'b0);

    // Degenerate triangle: one pixel, one write.
    clear_wf();
    plot(300, 200);
    run_fill(300, 200, 77, 300, 200, 77, 300, 200, 77, -10, 24'h445566, 1'b0);
    chk("degenerate_writes", last_wr, 1);

    // Random triangles over random wireframe bits and random z-buffer contents.
    for (int k = 0; k < 4; k++) begin
      int vx[3], vy[3], vz, hg;
      logic [23:0] col;
      ox = $urandom_range(0, 600);
      oy = $urandom_range(0, 440);
      for (int j = 0; j < 3; j++) begin
        vx[j] = ox + $urandom_range(0, 30);
        vy[j] = oy + $urandom_range(0, 30);
      end
      vz  = $urandom_range(0, 255);
      hg  = int'($urandom_range(0, 100)) - 50;
      col = 24'($urandom);
      set_box(vx[0], vy[0], vx[1], vy[1], vx[2], vy[2]);
      clear_wf();
      for (int yy = bymin; yy <= bymax; yy++) begin
        for (int xx = bxmin; xx <= bxmax; xx++) begin
          zmem[yy * W + xx]  = 8'($urandom);
          fbmem[yy * W + xx] = 24'($urandom);
        end
        if ($urandom_range(0, 3) != 0)
          repeat ($urandom_range(1, 3))
            plot($urandom_range(((bxmin > 3) ? bxmin - 3 : 0), ((bxmax + 3 < W) ? bxmax + 3 : W - 1)), yy);
      end
      run_fill(vx[0], vy[0], vz, vx[1], vy[1], 0, vx[2], vy[2], 0, hg, col, 1'b0);
    end

    // Reset in the middle of a fill, then restart.
    clear_wf();
    draw_line(100, 100, 130, 100); draw_line(130, 100, 115, 120); draw_line(115, 120, 100, 100);
    load_tri(100, 100, 50, 130, 100, 50, 115, 120, 50, 0, 24'h123456);
    @(negedge tb_clk);
    bus.color_en = 1'b1;
    cyc = 0;
    while (bus.write_en !== 1'b1 && cyc < 5000) begin
      @(negedge tb_clk);
      cyc++;
    end
    chk("fill_reached", bus.write_en, 1);
    n_rst = 1'b1;
    bus.color_en = 1'b0;
    @(negedge tb_clk);
    chk_outputs_zero();
    n_rst = 1'b0;
    w0 = wr_cnt;
    repeat (10) @(negedge tb_clk);
    chk("no_write_after_rst", wr_cnt, w0);
    chk("idle_after_rst", bus.done, 0);
    run_fill(100, 100, 50, 130, 100, 50, 115, 120, 50, 0, 24'h123456, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
